avmm_mem_responder: RTL
=======================

Name: avmm_mem_responder

Overview:
- Avalon-MM agent (responder) memory that answers the fixed-latency read/write master port emitted by our HLS components (64-bit address, 8-bit byteenable, no waitrequest, no readdatavalid on the master side).
- Used in component-level simulation and small on-chip integrations as the memory behind vector pointers a/b/c.
- Includes a host backdoor port for preload and readback, plus sticky protocol-error reporting.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words; power of two, at least 2.
- READ_LATENCY, 3, cycles from the read-request edge to valid readdata; at least 1.
- BASE_ADDR, 64'h0, byte base address of word 0; must be aligned to DEPTH_WORDS*8.

Ports:
- clock  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- avs_address  in  64  byte address from the master
- avs_byteenable  in  8  byte lane enables; bit i covers writedata[8i+7:8i]
- avs_read  in  1  read request, one word per cycle
- avs_readdata  out  64  read data, valid exactly READ_LATENCY cycles after the request
- avs_readdatavalid  out  1  debug/bench qualifier for avs_readdata; the master ignores it
- avs_write  in  1  write request
- avs_writedata  in  64  write data
- host_we  in  1  backdoor write strobe; full word, no byte enables
- host_addr  in  $clog2(DEPTH_WORDS)  backdoor word index
- host_wdata  in  64  backdoor write data
- host_rdata  out  64  backdoor read data, 1-cycle latency, read-first
- err_sticky  out  3  {overlap, out_of_range, misaligned}; cleared only by reset
- rd_count  out  32  accepted Avalon reads (optional feature)
- wr_count  out  32  accepted Avalon writes (optional feature)

Behaviour:
- Reset values: avs_readdata=0, avs_readdatavalid=0, host_rdata=0, err_sticky=0, counters=0. Memory contents are not reset.
- Decode: off = avs_address - BASE_ADDR; idx = off[3+AW-1:3] where AW = $clog2(DEPTH_WORDS).
  - In range: the bits of off above 3+AW-1 are zero.
  - Misaligned: address[2:0] != 0. Sets err_sticky[0]. The access still proceeds at idx, because the master always issues aligned addresses.
- Write, avs_write=1 and in range: for each i with byteenable[i]=1, mem[idx] byte i <= writedata byte i at the edge. Other bytes are unchanged. byteenable=0 is a legal no-op and is still counted.
- Read, avs_read=1 and avs_write=0:
  - Enters the read pipeline (sub-module) as {valid, idx, in_range}.
  - Memory is sampled at stage 1, read-first (a write to the same word in the same cycle is not visible).
  - Data is delayed READ_LATENCY-1 further stages.
  - On stage-READ_LATENCY output valid: avs_readdata <= data, or 64'h0 if out of range, and avs_readdatavalid=1 for one cycle.
  - Otherwise avs_readdata holds its last value and avs_readdatavalid=0.
  - Back-to-back reads, one per cycle, are fully pipelined with no bubbles.
- Simultaneous avs_read and avs_write: the write is performed, the read is dropped (no valid pulse), and err_sticky[2] is set.
- Out-of-range write is dropped and sets err_sticky[1]. Out-of-range read returns 0 at the normal latency and sets err_sticky[1].
- Host port:
  - host_we writes the full word.
  - If an Avalon write targets the same idx in the same cycle, bytes with byteenable=1 take Avalon data and the remaining bytes take host data.
  - host_rdata <= mem[host_addr] each cycle, read-first.
- Reset mid-operation: all pipeline valids clear asynchronously, so in-flight reads never produce a valid pulse. Memory retains its data.

Optional Feature:
- Macro: AVMM_MEM_RESPONDER_STATS_EN.
- Defined: rd_count and wr_count increment on each accepted Avalon read and write (dropped reads excluded; out-of-range accesses included). Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are present but tied to 0, and no counter flops are inferred.

Decomposition:
- Package avmm_resp_pkg holds:
  - constants AVMM_ADDR_W=64, AVMM_DATA_W=64, AVMM_BE_W=8;
  - error bit indices ERR_MISALIGN=0, ERR_RANGE=1, ERR_OVERLAP=2;
  - typedef rd_stage_t {valid, in_range, idx, data}.
- Sub-module avmm_resp_rd_pipe: a READ_LATENCY-deep delay line of rd_stage_t with async-clear valids.

Test Plan:
- Write addr 0x10, be=FF, data 0x1122334455667788; read 0x10 next cycle -> readdata=0x1122334455667788 exactly 3 cycles after the read edge, avs_readdatavalid pulses once.
- Word 2 preloaded 0 via host; write 0x10 be=0x0F, data 0xAAAAAAAABBBBBBBB -> host read of idx 2 returns 0x00000000BBBBBBBB.
- Reads every cycle at 0x0, 0x8, 0x10, 0x18 with host-preloaded 1..4 -> readdata 1,2,3,4 on four consecutive cycles starting at latency 3.
- Read at byte address DEPTH_WORDS*8 -> readdata=0 at latency 3, err_sticky=3'b010; write to the same address leaves the memory unchanged.
- Read and write asserted together at 0x8 -> word updated, no valid pulse, err_sticky[2]=1; with AVMM_MEM_RESPONDER_STATS_EN, wr_count=1 and rd_count=0.
- Issue a read, assert resetn=0 one cycle later, release -> no avs_readdatavalid pulse, readdata=0, preloaded memory intact on a subsequent read.

Source files
------------

// File: rtl/avmm_resp_pkg.sv
// Shared constants and types for the Avalon-MM memory responder.
package avmm_resp_pkg;

  localparam int AVMM_ADDR_W = 64;
  localparam int AVMM_DATA_W = 64;
  localparam int AVMM_BE_W   = 8;

  // Bit positions inside err_sticky
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_OVERLAP  = 2;

  // Word index carried through the read pipeline; wide enough for any
  // practical DEPTH_WORDS, upper bits are trimmed by synthesis.
  localparam int RD_IDX_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   in_range;
    logic [RD_IDX_W-1:0]    idx;
    logic [AVMM_DATA_W-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/avmm_resp_rd_pipe.sv
// Read delay line: READ_LATENCY stages of rd_stage_t. Only the valid bits
// are cleared by reset so in-flight reads vanish; payload is left alone.
module avmm_resp_rd_pipe
  import avmm_resp_pkg::*;
#(
  parameter int READ_LATENCY = 3
) (
  input  logic      clock,
  input  logic      resetn,
  input  rd_stage_t stage_in,
  output rd_stage_t stage_out
);

  rd_stage_t stage_p [READ_LATENCY];

  // Shift the request and its sampled word down the line each cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_p[i].valid <= 1'b0;
      end
    end else begin
      stage_p[0] <= stage_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign stage_out = stage_p[READ_LATENCY-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM responder memory with fixed read latency, host backdoor port
// and sticky protocol-error flags.
// Optional access counters enabled by defining AVMM_MEM_RESPONDER_STATS_EN;
// without it rd_count/wr_count are constant zero.
module avmm_mem_responder
  import avmm_resp_pkg::*;
#(
  parameter int               DEPTH_WORDS  = 1024,
  parameter int               READ_LATENCY = 3,
  parameter logic [63:0]      BASE_ADDR    = 64'h0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [AVMM_ADDR_W-1:0]         avs_address,
  input  logic [AVMM_BE_W-1:0]           avs_byteenable,
  input  logic                           avs_read,
  output logic [AVMM_DATA_W-1:0]         avs_readdata,
  output logic                           avs_readdatavalid,
  input  logic                           avs_write,
  input  logic [AVMM_DATA_W-1:0]         avs_writedata,
  input  logic                           host_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] host_addr,
  input  logic [AVMM_DATA_W-1:0]         host_wdata,
  output logic [AVMM_DATA_W-1:0]         host_rdata,
  output logic [2:0]                     err_sticky,
  output logic [31:0]                    rd_count,
  output logic [31:0]                    wr_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [AVMM_DATA_W-1:0] mem [DEPTH_WORDS];

  logic [AVMM_ADDR_W-1:0] off;
  logic [AW-1:0]          idx;
  logic                   in_range;
  logic                   misaligned;
  logic                   access;
  logic                   rd_accept;
  logic                   wr_en;
  rd_stage_t              pipe_in;
  rd_stage_t              pipe_out;
  logic                   unused_ok;

  assign off        = avs_address - BASE_ADDR;
  assign idx        = off[3+AW-1:3];
  assign in_range   = (off[AVMM_ADDR_W-1:3+AW] == '0);
  assign misaligned = |avs_address[2:0];
  assign access     = avs_read | avs_write;
  // A read colliding with a write is dropped; the write wins
  assign rd_accept  = avs_read & ~avs_write;
  assign wr_en      = avs_write & in_range;

  // Memory update: host writes the full word, Avalon byte lanes override it
  // when both target the same word in the same cycle
  always_ff @(posedge clock) begin
    if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
    for (int i = 0; i < AVMM_BE_W; i++) begin
      if (wr_en && avs_byteenable[i]) begin
        mem[idx][8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
  end

  // Backdoor readback, read-first with one cycle of latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      host_rdata <= '0;
    end else begin
      host_rdata <= mem[host_addr];
    end
  end

  // Stage-1 request: memory sampled before this edge's write lands
  always_comb begin
    pipe_in          = '0;
    pipe_in.valid    = rd_accept;
    pipe_in.in_range = in_range;
    pipe_in.idx      = RD_IDX_W'(idx);
    pipe_in.data     = mem[idx];
  end

  avmm_resp_rd_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .resetn    (resetn),
    .stage_in  (pipe_in),
    .stage_out (pipe_out)
  );

  // Read return: out-of-range reads complete with zero data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= pipe_out.valid;
      if (pipe_out.valid) begin
        avs_readdata <= pipe_out.in_range ? pipe_out.data : '0;
      end
    end
  end

  // Sticky protocol-error flags, cleared only by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_sticky <= '0;
    end else begin
      if (access && misaligned) err_sticky[ERR_MISALIGN] <= 1'b1;
      if (access && !in_range)  err_sticky[ERR_RANGE]    <= 1'b1;
      if (avs_read && avs_write) err_sticky[ERR_OVERLAP] <= 1'b1;
    end
  end

`ifdef AVMM_MEM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Saturating counters of accepted accesses, out-of-range included
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_accept && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (avs_write && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  // Index copy and byte offset are carried for visibility only
  assign unused_ok = ^{pipe_out.idx, off[2:0]};

endmodule
